// File: rtl/subservient_loader_pkg.sv
// Shared definitions for the subservient boot loader.
package subservient_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hf;

endpackage

// File: rtl/subservient_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them over the
// debug Wishbone port, then releases the SoC from reset/debug mode to run from address 0.
module subservient_loader
    import subservient_loader_pkg::*;
#(
    parameter int unsigned MEMSIZE  = 1024,
    parameter logic [31:0] BASE_ADR = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    output logic        o_core_rst,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic        i_wb_dbg_ack,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [31:0] ADR_END = BASE_ADR + MEMSIZE;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [1:0]  idx_q;
    logic        last_q;
    logic        run_q;
    logic        start_load;
    logic        store;
    logic        wr_ack;

    always_comb begin
        state_d      = state_q;
        start_load   = 1'b0;
        store        = 1'b0;
        wr_ack       = 1'b0;
        o_byte_ready = 1'b0;
        o_wb_dbg_stb = 1'b0;
        o_core_rst   = 1'b1;
        o_debug_mode = 1'b1;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_COLLECT;
                    start_load = 1'b1;
                end
            end
            S_COLLECT: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid) begin
                    // A byte arriving with the address window exhausted is dropped.
                    if (adr_q >= ADR_END) begin
                        state_d = S_ERR;
                    end else begin
                        store = 1'b1;
                        if (idx_q == 2'd3 || i_byte_last)
                            state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                o_wb_dbg_stb = 1'b1;
                if (i_wb_dbg_ack) begin
                    wr_ack  = 1'b1;
                    state_d = last_q ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                // A restart re-asserts reset/debug in the same cycle i_start is seen.
                if (i_start) begin
                    state_d    = S_COLLECT;
                    start_load = 1'b1;
                end else begin
                    o_done       = 1'b1;
                    o_debug_mode = 1'b0;
                    o_core_rst   = ~run_q;
                end
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_start) begin
                    state_d    = S_COLLECT;
                    start_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            adr_q   <= BASE_ADR;
            dat_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Core reset lags debug-mode release by one cycle so the debug mux settles.
            run_q   <= (state_q == S_DONE) && (state_d == S_DONE);
            if (start_load) begin
                adr_q  <= BASE_ADR;
                dat_q  <= '0;
                idx_q  <= '0;
                last_q <= 1'b0;
            end else if (store) begin
                dat_q[{idx_q, 3'b000} +: 8] <= i_byte;
                idx_q  <= idx_q + 2'd1;
                last_q <= i_byte_last;
            end else if (wr_ack) begin
                adr_q  <= adr_q + 32'd4;
                dat_q  <= '0;
                idx_q  <= '0;
                last_q <= 1'b0;
            end
        end
    end

    assign o_wb_dbg_adr = adr_q;
    assign o_wb_dbg_dat = dat_q;
    assign o_wb_dbg_sel = WB_SEL_ALL;
    assign o_wb_dbg_we  = o_wb_dbg_stb;

endmodule

// File: tb/tb_subservient_loader.sv
// Scoreboard bench for subservient_loader: images are turned into expected word writes
// by a byte-level reference model; a monitor checks every Wishbone strobe against them.
module tb_subservient_loader;

    localparam int unsigned MEMSIZE  = 16;
    localparam logic [31:0] BASE_ADR = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        i_byte_valid = 1'b0;
    logic        i_byte_last = 1'b0;
    logic        o_byte_ready;
    logic        o_core_rst;
    logic        o_debug_mode;
    logic [31:0] o_wb_dbg_adr;
    logic [31:0] o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we;
    logic        o_wb_dbg_stb;
    logic        i_wb_dbg_ack = 1'b0;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;

    subservient_loader #(.MEMSIZE(MEMSIZE), .BASE_ADR(BASE_ADR)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_byte_last  (i_byte_last),
        .o_byte_ready (o_byte_ready),
        .o_core_rst   (o_core_rst),
        .o_debug_mode (o_debug_mode),
        .o_wb_dbg_adr (o_wb_dbg_adr),
        .o_wb_dbg_dat (o_wb_dbg_dat),
        .o_wb_dbg_sel (o_wb_dbg_sel),
        .o_wb_dbg_we  (o_wb_dbg_we),
        .o_wb_dbg_stb (o_wb_dbg_stb),
        .i_wb_dbg_ack (i_wb_dbg_ack),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [63:0] exp_q[$];          // {adr, dat} of each write still owed
    int unsigned ack_delay = 0;
    int unsigned stb_age   = 0;
    bit          stray_ack = 1'b0;
    int unsigned last_result = 0;   // 0 idle, 1 done, 2 err

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone slave: ack after ack_delay wait states; optional stray acks while idle.
    always @(posedge clk) begin
        #1;
        if (o_wb_dbg_stb) begin
            i_wb_dbg_ack = (stb_age == ack_delay);
            stb_age++;
        end else begin
            i_wb_dbg_ack = stray_ack && ($urandom_range(0, 3) == 0);
            stb_age = 0;
        end
    end

    // Monitor: every strobed cycle must match the oldest owed write; pop on ack.
    always @(negedge clk) begin
        if (o_wb_dbg_stb) begin
            chk1("stb_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                chk("wr_adr", o_wb_dbg_adr, exp_q[0][63:32]);
                chk("wr_dat", o_wb_dbg_dat, exp_q[0][31:0]);
                chk("wr_sel", {28'h0, o_wb_dbg_sel}, 32'hf);
                chk1("wr_we", o_wb_dbg_we, 1'b1);
                chk1("ready_in_write", o_byte_ready, 1'b0);
                if (i_wb_dbg_ack)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_image(input logic [7:0] img[$], input int unsigned dly,
                             input bit gaps, input bit stray);
        int unsigned n;
        int unsigned lim;
        int unsigned nw;
        int unsigned sent;
        int unsigned cyc;
        logic [31:0] word;
        bit          ovf;
        bit          taken;
        bit          want_stb;
        n   = img.size();
        ovf = (n > MEMSIZE);
        lim = ovf ? MEMSIZE + 1 : n;
        nw  = ovf ? MEMSIZE / 4 : (n + 3) / 4;
        for (int unsigned w = 0; w < nw; w++) begin
            word = '0;
            for (int unsigned b = 0; b < 4; b++)
                if (4 * w + b < n)
                    word = word | (32'(img[4 * w + b]) << (8 * b));
            exp_q.push_back({BASE_ADR + 32'(4 * w), word});
        end
        ack_delay = dly;

        @(posedge clk); #1;
        i_start = 1'b1;
        if (last_result == 1) begin
            @(negedge clk);
            chk1("restart_core_rst", o_core_rst, 1'b1);
            chk1("restart_debug", o_debug_mode, 1'b1);
            chk1("restart_done", o_done, 1'b0);
        end
        @(posedge clk); #1;
        i_start = 1'b0;
        if (last_result == 2) begin
            @(negedge clk);
            chk1("restart_err_clear", o_err, 1'b0);
            @(posedge clk); #1;
        end

        sent = 0;
        cyc = 0;
        want_stb = 1'b0;
        while (sent < lim && cyc < 4000) begin
            i_byte       = img[sent];
            i_byte_last  = (sent == n - 1);
            i_byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_start      = stray && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (want_stb) begin
                chk1("stb_latency", o_wb_dbg_stb, 1'b1);
                want_stb = 1'b0;
            end
            taken = o_byte_ready && i_byte_valid;
            @(posedge clk); #1;
            if (taken) begin
                want_stb = (sent < MEMSIZE) && ((sent % 4 == 3) || (sent == n - 1));
                sent++;
            end
            cyc++;
        end
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        i_start      = 1'b0;
        if (sent < lim)
            chk1("byte_timeout", 1'b0, 1'b1);
        if (want_stb) begin
            @(negedge clk);
            chk1("stb_latency", o_wb_dbg_stb, 1'b1);
        end

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_done && !o_err && cyc < 400);

        if (ovf) begin
            chk1("err_set", o_err, 1'b1);
            chk1("err_core_rst", o_core_rst, 1'b1);
            chk1("err_debug", o_debug_mode, 1'b1);
            chk1("err_done", o_done, 1'b0);
            chk1("err_ready", o_byte_ready, 1'b0);
            chk("err_pending", 32'(exp_q.size()), 32'd0);
            repeat (6) @(negedge clk);
            chk1("err_hold", o_err, 1'b1);
            chk1("err_hold_core_rst", o_core_rst, 1'b1);
            chk1("err_no_stb", o_wb_dbg_stb, 1'b0);
            last_result = 2;
        end else begin
            chk1("done_set", o_done, 1'b1);
            chk1("done_debug_off", o_debug_mode, 1'b0);
            chk1("done_core_rst_held", o_core_rst, 1'b1);
            chk("done_pending", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            chk1("done_core_run", o_core_rst, 1'b0);
            chk1("done_hold", o_done, 1'b1);
            chk1("done_debug_hold", o_debug_mode, 1'b0);
            chk1("done_ready", o_byte_ready, 1'b0);
            chk1("done_err", o_err, 1'b0);
            last_result = 1;
        end
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_stb"}, o_wb_dbg_stb, 1'b0);
        chk1({tag, "_we"}, o_wb_dbg_we, 1'b0);
        chk({tag, "_adr"}, o_wb_dbg_adr, BASE_ADR);
        chk({tag, "_dat"}, o_wb_dbg_dat, 32'h0);
        chk1({tag, "_core_rst"}, o_core_rst, 1'b1);
        chk1({tag, "_debug"}, o_debug_mode, 1'b1);
        chk1({tag, "_ready"}, o_byte_ready, 1'b0);
        chk1({tag, "_done"}, o_done, 1'b0);
        chk1({tag, "_err"}, o_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  img[$];
        int unsigned cyc;
        int unsigned len;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        img.delete();
        for (int unsigned i = 1; i <= 8; i++) img.push_back(8'(i));
        run_image(img, 0, 1'b0, 1'b0);

        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_image(img, 0, 1'b0, 1'b0);

        img.delete();
        for (int unsigned i = 0; i < 8; i++) img.push_back(8'($urandom));
        run_image(img, 3, 1'b0, 1'b0);

        img.delete();
        for (int unsigned i = 0; i < MEMSIZE + 1; i++) img.push_back(8'(8'h10 + i));
        run_image(img, 0, 1'b0, 1'b0);

        img.delete();
        for (int unsigned i = 0; i < 6; i++) img.push_back(8'($urandom));
        run_image(img, 1, 1'b1, 1'b0);

        // Reset while a write is waiting for its ack.
        ack_delay = 1000;
        exp_q.push_back({BASE_ADR, 32'h44332211});
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            i_byte       = 8'(8'h11 * i);
            i_byte_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_byte_valid = 1'b0;
        cyc = 0;
        while (!o_wb_dbg_stb && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk1("rst_test_stb_seen", o_wb_dbg_stb, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        exp_q.delete();
        ack_delay = 0;
        last_result = 0;

        img = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h99, 8'h66, 8'h12};
        run_image(img, 0, 1'b0, 1'b0);

        stray_ack = 1'b1;
        for (int unsigned t = 0; t < 14; t++) begin
            img.delete();
            len = $urandom_range(1, MEMSIZE + 3);
            for (int unsigned i = 0; i < len; i++) img.push_back(8'($urandom));
            run_image(img, $urandom_range(0, 3), 1'b1, 1'b1);
        end
        stray_ack = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
